// File: rtl/fc_pkg.sv
// Shared types and parameter-memory address map for the fc classifier sequencer.
package fc_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_L1_IN,
    S_L1_W,
    S_L1_B,
    S_L1_RUN,
    S_WB,
    S_L2_W,
    S_L2_B,
    S_L2_RUN,
    S_CMP,
    S_FIN
  } seq_state_e;

  typedef enum logic [1:0] {
    INPUT  = 2'd0,
    WEIGHT = 2'd1,
    BIAS   = 2'd2
  } buf_sel_e;

  localparam int unsigned ADDR_IN = 0;

  // Word offsets of each region, packed back to back in load order.
  function automatic int unsigned addr_w1(input int unsigned n0);
    return n0;
  endfunction

  function automatic int unsigned addr_b1(input int unsigned n0, input int unsigned n1);
    return addr_w1(n0) + n0 * n1;
  endfunction

  function automatic int unsigned addr_act(input int unsigned n0, input int unsigned n1);
    return addr_b1(n0, n1) + n1;
  endfunction

  function automatic int unsigned addr_w2(input int unsigned n0, input int unsigned n1);
    return addr_act(n0, n1) + n1;
  endfunction

  function automatic int unsigned addr_b2(input int unsigned n0, input int unsigned n1,
                                          input int unsigned n2);
    return addr_w2(n0, n1) + n1 * n2;
  endfunction

endpackage

// File: rtl/fc_addr_gen.sv
// Shared address/index generator: issues len reads (or writes) from base, then
// replays the read indices one cycle later as register-file write indices.
module fc_addr_gen #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_wb,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [IDX_W-1:0]  i_len,
  output logic              o_rd_en,
  output logic              o_wb_en,
  output logic [ADDR_W-1:0] o_addr,
  output logic [IDX_W-1:0]  o_cnt,
  output logic              o_buf_wr_en,
  output logic [IDX_W-1:0]  o_buf_idx,
  output logic              o_issue_last,
  output logic              o_wr_last
);

  logic              r_rd_en;
  logic              r_wb_en;
  logic              r_buf_wr;
  logic [IDX_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_len;
  logic [IDX_W-1:0]  r_buf_idx;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_addr;

  logic w_active;
  logic w_cnt_last;

  assign w_active   = r_rd_en | r_wb_en;
  assign w_cnt_last = (r_cnt == r_len - IDX_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_en   <= 1'b0;
      r_wb_en   <= 1'b0;
      r_buf_wr  <= 1'b0;
      r_cnt     <= '0;
      r_len     <= '0;
      r_buf_idx <= '0;
      r_base    <= '0;
      r_addr    <= '0;
    end else begin
      r_buf_wr  <= r_rd_en;
      r_buf_idx <= r_rd_en ? r_cnt : '0;
      if (i_load) begin
        r_rd_en <= ~i_wb;
        r_wb_en <= i_wb;
        r_cnt   <= '0;
        r_len   <= i_len;
        r_base  <= i_base;
        r_addr  <= i_base;
      end else if (w_active) begin
        if (w_cnt_last) begin
          r_rd_en <= 1'b0;
          r_wb_en <= 1'b0;
          r_cnt   <= '0;
          r_addr  <= '0;
        end else begin
          r_cnt  <= r_cnt + IDX_W'(1);
          r_addr <= r_base + ADDR_W'(r_cnt + IDX_W'(1));
        end
      end
    end
  end

  assign o_rd_en      = r_rd_en;
  assign o_wb_en      = r_wb_en;
  assign o_addr       = r_addr;
  assign o_cnt        = r_cnt;
  assign o_buf_wr_en  = r_buf_wr;
  assign o_buf_idx    = r_buf_idx;
  assign o_issue_last = w_active & w_cnt_last;
  assign o_wr_last    = r_buf_wr & (r_buf_idx == r_len - IDX_W'(1));

endmodule

// File: rtl/fc_layer_sequencer.sv
// Control sequencer for the two-stage fc classifier: loads layer files, runs
// both layers, writes back layer-1 activations, runs argmax. Optional: FC_SEQ_PERF_EN.
module fc_layer_sequencer
  import fc_pkg::*;
#(
  parameter int unsigned N0     = 3,
  parameter int unsigned N1     = 2,
  parameter int unsigned N2     = 10,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [3:0]        result,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              buf_wr_en,
  output logic              buf_layer,
  output logic [1:0]        buf_sel,
  output logic [IDX_W-1:0]  buf_idx,
  output logic [DATA_W-1:0] buf_data,
  output logic [1:0]        layer_start,
  input  logic [1:0]        layer_done,
  output logic [IDX_W-1:0]  out_rd_idx,
  input  logic [DATA_W-1:0] out_rd_data,
  output logic              cmp_start,
  input  logic              cmp_done,
  input  logic [3:0]        cmp_result
`ifdef FC_SEQ_PERF_EN
  , output logic [31:0]     perf_cycles
`endif
);

  localparam logic [ADDR_W-1:0] BASE_IN  = ADDR_W'(ADDR_IN);
  localparam logic [ADDR_W-1:0] BASE_W1  = ADDR_W'(addr_w1(N0));
  localparam logic [ADDR_W-1:0] BASE_B1  = ADDR_W'(addr_b1(N0, N1));
  localparam logic [ADDR_W-1:0] BASE_ACT = ADDR_W'(addr_act(N0, N1));
  localparam logic [ADDR_W-1:0] BASE_W2  = ADDR_W'(addr_w2(N0, N1));
  localparam logic [ADDR_W-1:0] BASE_B2  = ADDR_W'(addr_b2(N0, N1, N2));

  seq_state_e  r_state;
  logic        r_busy;
  logic        r_done;
  logic        r_armed;
  logic [3:0]  r_result;
  logic        r_buf_layer;
  buf_sel_e    r_buf_sel;
  logic [1:0]  r_layer_start;
  logic        r_cmp_start;

  logic              w_load;
  logic              w_load_wb;
  logic [ADDR_W-1:0] w_base;
  logic [IDX_W-1:0]  w_len;
  logic              w_rd_en;
  logic              w_wb_en;
  logic              w_buf_wr;
  logic              w_issue_last;
  logic              w_wr_last;
  logic [ADDR_W-1:0] w_addr;
  logic [IDX_W-1:0]  w_cnt;
  logic [IDX_W-1:0]  w_buf_idx;
  logic              w_start_ok;
  logic              w_l1_fin;
  logic              w_l2_fin;

  // A done flag is only trusted once layer_start has been high for a full cycle.
  assign w_start_ok = (r_state == S_IDLE) & start;
  assign w_l1_fin   = r_armed & layer_done[0];
  assign w_l2_fin   = r_armed & layer_done[1];

  // Phase launch: asserted in the cycle before the next phase's first access.
  always_comb begin
    w_load    = 1'b0;
    w_load_wb = 1'b0;
    w_base    = '0;
    w_len     = '0;
    case (r_state)
      S_IDLE:   if (w_start_ok)   begin w_load = 1'b1; w_base = BASE_IN;  w_len = IDX_W'(N0);      end
      S_L1_IN:  if (w_wr_last)    begin w_load = 1'b1; w_base = BASE_W1;  w_len = IDX_W'(N0 * N1); end
      S_L1_W:   if (w_wr_last)    begin w_load = 1'b1; w_base = BASE_B1;  w_len = IDX_W'(N1);      end
      S_L1_RUN: if (w_l1_fin)     begin w_load = 1'b1; w_load_wb = 1'b1;
                                        w_base = BASE_ACT; w_len = IDX_W'(N1);                    end
      S_WB:     if (w_issue_last) begin w_load = 1'b1; w_base = BASE_W2;  w_len = IDX_W'(N1 * N2); end
      S_L2_W:   if (w_wr_last)    begin w_load = 1'b1; w_base = BASE_B2;  w_len = IDX_W'(N2);      end
      default:  ;
    endcase
  end

  fc_addr_gen #(
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_load),
    .i_wb         (w_load_wb),
    .i_base       (w_base),
    .i_len        (w_len),
    .o_rd_en      (w_rd_en),
    .o_wb_en      (w_wb_en),
    .o_addr       (w_addr),
    .o_cnt        (w_cnt),
    .o_buf_wr_en  (w_buf_wr),
    .o_buf_idx    (w_buf_idx),
    .o_issue_last (w_issue_last),
    .o_wr_last    (w_wr_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_armed       <= 1'b0;
      r_result      <= '0;
      r_buf_layer   <= 1'b0;
      r_buf_sel     <= INPUT;
      r_layer_start <= '0;
      r_cmp_start   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (w_start_ok) begin
          r_busy      <= 1'b1;
          r_buf_layer <= 1'b0;
          r_buf_sel   <= INPUT;
          r_state     <= S_L1_IN;
        end
        S_L1_IN: if (w_wr_last) begin r_buf_sel <= WEIGHT; r_state <= S_L1_W; end
        S_L1_W:  if (w_wr_last) begin r_buf_sel <= BIAS;   r_state <= S_L1_B; end
        S_L1_B:  if (w_wr_last) begin
          r_layer_start <= 2'b01;
          r_armed       <= 1'b0;
          r_state       <= S_L1_RUN;
        end
        S_L1_RUN: begin
          r_armed <= 1'b1;
          if (w_l1_fin) begin r_layer_start <= '0; r_state <= S_WB; end
        end
        S_WB: if (w_issue_last) begin
          r_buf_layer <= 1'b1;
          r_buf_sel   <= WEIGHT;
          r_state     <= S_L2_W;
        end
        S_L2_W: if (w_wr_last) begin r_buf_sel <= BIAS; r_state <= S_L2_B; end
        S_L2_B: if (w_wr_last) begin
          r_layer_start <= 2'b10;
          r_armed       <= 1'b0;
          r_state       <= S_L2_RUN;
        end
        S_L2_RUN: begin
          r_armed <= 1'b1;
          if (w_l2_fin) begin
            r_layer_start <= '0;
            r_cmp_start   <= 1'b1;
            r_state       <= S_CMP;
          end
        end
        S_CMP: if (cmp_done) begin
          r_result    <= cmp_result;
          r_cmp_start <= 1'b0;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_FIN;
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FC_SEQ_PERF_EN
  logic [31:0] r_perf;

  // Counts every non-idle cycle of the run, FIN included; holds while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf <= '0;
    end else if (w_start_ok) begin
      r_perf <= '0;
    end else if ((r_state != S_IDLE) && (r_perf != '1)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cycles = r_perf;
`endif

  assign busy        = r_busy;
  assign done        = r_done;
  assign result      = r_result;
  assign mem_rd_en   = w_rd_en;
  assign mem_wr_en   = w_wb_en;
  assign mem_addr    = w_addr;
  assign out_rd_idx  = w_cnt;
  // Data paths are steered straight through; memory read and layer output are already registered upstream.
  assign mem_wr_data = w_wb_en ? out_rd_data : '0;
  assign buf_wr_en   = w_buf_wr;
  assign buf_layer   = r_buf_layer;
  assign buf_sel     = r_buf_sel;
  assign buf_idx     = w_buf_idx;
  assign buf_data    = w_buf_wr ? mem_rd_data : '0;
  assign layer_start = r_layer_start;
  assign cmp_start   = r_cmp_start;

endmodule
